// File: rtl/tanque_pkg.sv
// Shared constants for the water-tank sensor model: fault-select codes and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tanque_pkg;

  // Fault-select encoding driven onto Falha_sel
  localparam logic [1:0] FALHA_NENHUMA = 2'd0;  // no fault
  localparam logic [1:0] FALHA_L0      = 2'd1;  // low sensor stuck at 0
  localparam logic [1:0] FALHA_M0      = 2'd2;  // medium sensor stuck at 0
  localparam logic [1:0] FALHA_H1      = 2'd3;  // high sensor stuck at 1

  // Default geometry, thresholds and rates
  localparam int DEF_W          = 8;
  localparam int DEF_CAP        = 255;
  localparam int DEF_INIT_LEVEL = 0;
  localparam int DEF_TH_L       = 64;
  localparam int DEF_TH_M       = 128;
  localparam int DEF_TH_H       = 192;
  localparam int DEF_HYST       = 4;
  localparam int DEF_FILL_RATE  = 3;
  localparam int DEF_DRAIN_RATE = 2;
  localparam int DEF_TICK_DIV   = 4;

endpackage

// File: rtl/tanque_sensor_sim_sensor.sv
// One float sensor with hysteresis: sets at Nivel >= TH, clears below TH-HYST.
// Latency: raw follows the registered level with one clock of delay.
// Backpressure: none; evaluated every clock.
module sensor_histerese #(
  parameter int W    = 8,
  parameter int TH   = 64,
  parameter int HYST = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] Nivel,
  output logic         raw
);

  localparam logic [W-1:0] SET_LVL = W'(TH);
  localparam logic [W-1:0] CLR_LVL = W'(TH - HYST);

  logic raw_q;
  logic raw_d;

  // Next sensor state: set at/above threshold, clear below the band, else hold
  always_comb begin
    raw_d = raw_q;
    if (Nivel >= SET_LVL) begin
      raw_d = 1'b1;
    end else if (Nivel < CLR_LVL) begin
      raw_d = 1'b0;
    end
  end

  // Sensor state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= raw_d;
    end
  end

  assign raw = raw_q;

endmodule

// File: rtl/tanque_sensor_sim.sv
// Water-tank model: tick-paced saturating level integrator driving H/M/L float sensors.
// Latency: level moves on the tick edge; sensors follow one clock later; faults are combinational.
// Backpressure: none; Ve/Dreno are sampled only at tick edges.
module tanque_sensor_sim
  import tanque_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int CAP        = DEF_CAP,
  parameter int INIT_LEVEL = DEF_INIT_LEVEL,
  parameter int TH_L       = DEF_TH_L,
  parameter int TH_M       = DEF_TH_M,
  parameter int TH_H       = DEF_TH_H,
  parameter int HYST       = DEF_HYST,
  parameter int FILL_RATE  = DEF_FILL_RATE,
  parameter int DRAIN_RATE = DEF_DRAIN_RATE,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         Ve,
  input  logic         Dreno,
  input  logic [1:0]   Falha_sel,
  output logic         H,
  output logic         M,
  output logic         L,
  output logic [W-1:0] Nivel,
  output logic         Cheio,
  output logic         Vazio,
  output logic         Transbordo,
  output logic         Tick
);

  // Prescaler width stays at least one bit so TICK_DIV=1 still elaborates
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  // Signed arithmetic is two bits wider than the level so sum/underflow never wrap
  localparam int WS = W + 2;
  localparam logic signed [WS-1:0] FILL_S  = WS'(FILL_RATE);
  localparam logic signed [WS-1:0] DRAIN_S = WS'(DRAIN_RATE);
  localparam logic signed [WS-1:0] CAP_S   = WS'(CAP);
  localparam logic [W-1:0]         CAP_V   = W'(CAP);
  localparam logic [W-1:0]         INIT_V  = W'(INIT_LEVEL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  nivel_q, nivel_d;
  logic          transbordo_q, transbordo_d;
  logic          tick;

  logic signed [WS-1:0] delta;
  logic signed [WS-1:0] sum;
  logic [W-1:0]         nivel_next;

  logic raw_l, raw_m, raw_h;

  assign tick = (cnt_q == CNT_MAX);

  // Prescaler: free-running 0..TICK_DIV-1
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Level integrator: net fill/drain, clamped to [0, CAP], applied only on tick
  always_comb begin
    delta = '0;
    if (Ve) begin
      delta = delta + FILL_S;
    end
    if (Dreno) begin
      delta = delta - DRAIN_S;
    end
    sum = $signed({2'b00, nivel_q}) + delta;
    if (sum < 0) begin
      nivel_next = '0;
    end else if (sum > CAP_S) begin
      nivel_next = CAP_V;
    end else begin
      nivel_next = sum[W-1:0];
    end
    nivel_d = tick ? nivel_next : nivel_q;
    // Overflow means trying to fill an already full tank; reaching CAP is not overflow
    transbordo_d = transbordo_q | (tick & Ve & (nivel_q == CAP_V));
  end

  // Prescaler, level and sticky overflow registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      nivel_q      <= INIT_V;
      transbordo_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      nivel_q      <= nivel_d;
      transbordo_q <= transbordo_d;
    end
  end

  sensor_histerese #(.W(W), .TH(TH_L), .HYST(HYST)) u_sens_l (
    .clk     (clk),
    .reset_n (reset_n),
    .Nivel   (nivel_q),
    .raw     (raw_l)
  );

  sensor_histerese #(.W(W), .TH(TH_M), .HYST(HYST)) u_sens_m (
    .clk     (clk),
    .reset_n (reset_n),
    .Nivel   (nivel_q),
    .raw     (raw_m)
  );

  sensor_histerese #(.W(W), .TH(TH_H), .HYST(HYST)) u_sens_h (
    .clk     (clk),
    .reset_n (reset_n),
    .Nivel   (nivel_q),
    .raw     (raw_h)
  );

  // Fault override sits after the sensor registers so it acts within the same cycle
  always_comb begin
    L = raw_l;
    M = raw_m;
    H = raw_h;
    case (Falha_sel)
      FALHA_L0: L = 1'b0;
      FALHA_M0: M = 1'b0;
      FALHA_H1: H = 1'b1;
      default:  ;
    endcase
  end

  assign Nivel      = nivel_q;
  assign Cheio      = (nivel_q == CAP_V);
  assign Vazio      = (nivel_q == '0);
  assign Transbordo = transbordo_q;
  assign Tick       = tick;

endmodule

// File: tb/tb_tanque_sensor_sim.sv
// Directed bench for tanque_sensor_sim: fill, overflow, drain, faults, async reset, hysteresis.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_tanque_sensor_sim;

  logic       clk = 1'b0;
  logic       reset_n, Ve, Dreno;
  logic [1:0] Falha_sel;
  logic       H, M, L, Cheio, Vazio, Transbordo, Tick;
  logic [7:0] Nivel;

  logic       rst2_n, Ve2, Dreno2;
  logic [1:0] falha2;
  logic       H2, M2, L2, Cheio2, Vazio2, Transbordo2, Tick2;
  logic [7:0] Nivel2;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  tanque_sensor_sim dut (
    .clk(clk), .reset_n(reset_n), .Ve(Ve), .Dreno(Dreno), .Falha_sel(Falha_sel),
    .H(H), .M(M), .L(L), .Nivel(Nivel), .Cheio(Cheio), .Vazio(Vazio),
    .Transbordo(Transbordo), .Tick(Tick)
  );

  tanque_sensor_sim #(.INIT_LEVEL(62)) dut_hyst (
    .clk(clk), .reset_n(rst2_n), .Ve(Ve2), .Dreno(Dreno2), .Falha_sel(falha2),
    .H(H2), .M(M2), .L(L2), .Nivel(Nivel2), .Cheio(Cheio2), .Vazio(Vazio2),
    .Transbordo(Transbordo2), .Tick(Tick2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Advance to a given edge count since the last reset release
  task automatic go(input int n);
    while (ecount < n) step();
  endtask

  initial begin
    reset_n = 1'b0; Ve = 1'b0; Dreno = 1'b0; Falha_sel = 2'd0;
    rst2_n = 1'b0; Ve2 = 1'b0; Dreno2 = 1'b0; falha2 = 2'd0;
    #2;
    chk("rst_nivel", Nivel, 0);
    chk("rst_hml", {H, M, L}, 0);
    chk("rst_vazio", Vazio, 1);
    chk("rst_cheio", Cheio, 0);
    chk("rst_transb", Transbordo, 0);
    chk("rst_tick", Tick, 0);

    // Fill from empty
    @(negedge clk);
    reset_n = 1'b1; ecount = 0; Ve = 1'b1;
    go(2);   chk("tick_e2", Tick, 0);
    go(3);   chk("tick_e3", Tick, 1);
    go(4);   chk("fill_t1", Nivel, 3);   chk("tick_e4", Tick, 0);
    go(88);  chk("fill_t22", Nivel, 66); chk("L_lat", L, 0);
    go(89);  chk("L_rise", L, 1);        chk("M_low", M, 0);
    go(172); chk("fill_t43", Nivel, 129); chk("M_lat", M, 0);
    go(173); chk("M_rise", M, 1);
    go(256); chk("fill_t64", Nivel, 192); chk("H_lat", H, 0);
    go(257); chk("H_rise", H, 1);
    go(336); chk("fill_t84", Nivel, 252); chk("cheio_t84", Cheio, 0);
    go(340); chk("fill_t85", Nivel, 255); chk("cheio_t85", Cheio, 1);
    chk("transb_at_cap", Transbordo, 0);
    go(344); chk("ovf_nivel", Nivel, 255); chk("ovf_flag", Transbordo, 1);

    // Drain from full
    Ve = 1'b0; Dreno = 1'b1;
    go(476); chk("drain_33", Nivel, 189);
    go(477); chk("H_hold_189", H, 1);
    go(480); chk("drain_34", Nivel, 187); chk("H_hold_lat", H, 1);
    go(481); chk("H_clear", H, 0);       chk("transb_sticky", Transbordo, 1);
    go(852); chk("drain_127", Nivel, 1); chk("vazio_1", Vazio, 0);
    go(856); chk("drain_128", Nivel, 0); chk("vazio", Vazio, 1);
    go(860); chk("no_wrap", Nivel, 0);

    // Refill to 129, then one simultaneous tick for +1 -> 130
    Ve = 1'b1; Dreno = 1'b0;
    go(1032); chk("refill_129", Nivel, 129);
    Dreno = 1'b1;
    go(1036); chk("net_delta", Nivel, 130);
    Ve = 1'b0; Dreno = 1'b0;
    go(1038); chk("f_base", {H, M, L}, 3'b011);
    Falha_sel = 2'd1; #1; chk("f_L0", {H, M, L}, 3'b010);
    Falha_sel = 2'd2; #1; chk("f_M0", {H, M, L}, 3'b001);
    Falha_sel = 2'd3; #1; chk("f_H1", {H, M, L}, 3'b111);
    Falha_sel = 2'd0; #1; chk("f_none", {H, M, L}, 3'b011);

    // Drain to 100, resume filling, then reset mid-tick between edges
    Dreno = 1'b1;
    go(1096); chk("drain_100", Nivel, 100);
    Dreno = 1'b0; Ve = 1'b1;
    go(1098);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_nivel", Nivel, 0);
    chk("arst_hml", {H, M, L}, 0);
    chk("arst_transb", Transbordo, 0);
    chk("arst_tick", Tick, 0);
    @(negedge clk);
    reset_n = 1'b1; ecount = 0;
    go(2); chk("rel_tick_e2", Tick, 0);
    go(3); chk("rel_tick_e3", Tick, 1); chk("rel_nivel_e3", Nivel, 0);
    go(4); chk("rel_nivel_e4", Nivel, 3);
    Ve = 1'b0;

    // Hysteresis on the second instance (INIT_LEVEL=62)
    chk("hy_rst_nivel", Nivel2, 62);
    chk("hy_rst_L", L2, 0);
    @(negedge clk);
    rst2_n = 1'b1; ecount = 0; Ve2 = 1'b1;
    go(4);  chk("hy_fill", Nivel2, 65);
    go(5);  chk("hy_L_set", L2, 1);
    Ve2 = 1'b0; Dreno2 = 1'b1;
    go(8);  chk("hy_63", Nivel2, 63);
    go(9);  chk("hy_L_63", L2, 1);
    go(12); chk("hy_61", Nivel2, 61);
    go(13); chk("hy_L_61", L2, 1);
    go(16); chk("hy_59", Nivel2, 59); chk("hy_L_lat", L2, 1);
    go(17); chk("hy_L_clr", L2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tanque_sensor_sim.md
Name: tanque_sensor_sim

Overview:
- Cycle-based water-tank model that acts as the sensor side of the level-sensor interface.
- Integrates fill (valve input `Ve`) and drain (consumption input) into a saturating level register.
- Drives the three float-sensor lines `H`, `M`, `L` with per-sensor hysteresis. The level decoder downstream consumes these lines.
- Includes fault injection to stimulate the decoder's error path, plus full, empty and overflow flags for the bench and the top-level display.

Parameters:
- W, 8, width of level register.
- CAP, 255, maximum level (≤ 2^W−1).
- INIT_LEVEL, 0, level loaded at reset.
- TH_L, 64, threshold of low sensor.
- TH_M, 128, threshold of medium sensor.
- TH_H, 192, threshold of high sensor (TH_L < TH_M < TH_H ≤ CAP).
- HYST, 4, hysteresis band (HYST ≤ TH_L).
- FILL_RATE, 3, level units added per tick while `Ve`=1.
- DRAIN_RATE, 2, level units removed per tick while `Dreno`=1.
- TICK_DIV, 4, clock cycles per simulation tick (≥ 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- Ve  in  1  inlet valve open.
- Dreno  in  1  outlet consumption active.
- Falha_sel  in  2  fault select: 0 none, 1 L stuck 0, 2 M stuck 0, 3 H stuck 1.
- H  out  1  high sensor.
- M  out  1  medium sensor.
- L  out  1  low sensor.
- Nivel  out  W  current level.
- Cheio  out  1  Nivel==CAP.
- Vazio  out  1  Nivel==0.
- Transbordo  out  1  sticky overflow flag.
- Tick  out  1  one-cycle pulse on each simulation tick.

Behaviour:
- One clock; reset is asynchronous and active-low (`reset_n`). Assertion takes effect immediately and does not wait for `clk`.
- Reset values:
  - Nivel=INIT_LEVEL, prescaler=0, Tick=0.
  - H=M=L=0 (raw sensor regs also 0).
  - Transbordo=0.
  - Cheio/Vazio reflect INIT_LEVEL.
- Prescaler:
  - Counts 0..TICK_DIV−1 and wraps.
  - Tick=1 in the cycle the counter equals TICK_DIV−1. The first Tick comes TICK_DIV cycles after reset release.
- Level update (on the clock edge while Tick=1):
  - delta = (Ve ? FILL_RATE : 0) − (Dreno ? DRAIN_RATE : 0), computed signed at W+2 bits.
  - Nivel_next = clamp(Nivel + delta, 0, CAP).
  - No update on non-tick cycles. Ve and Dreno are sampled only at tick edges.
- Saturation:
  - If Ve=1 at a tick edge with Nivel==CAP before the update, Transbordo is set. It is cleared only by reset.
  - Reaching CAP exactly does not set Transbordo.
  - Underflow clamps to 0 silently.
- Sensor registers (raw_X for X in {L,M,H}), updated every clock from the registered Nivel, so there is 1-cycle latency after a level change:
  - Set when Nivel ≥ TH_X.
  - Clear when Nivel < TH_X − HYST.
  - Hold otherwise.
- Outputs:
  - L/M/H = raw value with Falha_sel override applied combinationally on the registered raw value.
  - A fault change appears the same cycle. Removing the fault restores the raw value the same cycle.
- Cheio, Vazio: combinational compare on the registered Nivel.
- Simultaneous Ve and Dreno: the net delta applies (+1 with defaults).
- Reset asserted mid-tick: the prescaler restarts, and a partially counted tick is discarded.

Decomposition:
- Shared package `tanque_pkg`:
  - Fault-select encoding constants: FALHA_NENHUMA=0, FALHA_L0=1, FALHA_M0=2, FALHA_H1=3.
  - Default thresholds and rates.
- Sub-module `sensor_histerese`: one instance per sensor, parameters TH and HYST; inputs clk, reset_n, Nivel; output raw.
- The prescaler and level integrator stay in the top.

Test Plan:
- Fill from 0 (Ve=1, Dreno=0, defaults):
  - L rises 1 cycle after the 22nd tick (Nivel=66).
  - M after the 43rd tick (129).
  - H after the 64th tick (192).
  - Cheio=1 at the 85th tick (255), Transbordo still 0.
- Continue Ve=1 at Nivel=255 → next tick Nivel stays 255 and Transbordo=1. It stays 1 after Ve=0.
- Drain from 255 (Ve=0, Dreno=1):
  - H holds until the 34th tick (Nivel=187 < 188), then clears 1 cycle later.
  - Vazio=1 at Nivel=0, no wrap to 255.
- Hysteresis, INIT_LEVEL=62:
  - Fill one tick → 65, L=1.
  - Drain ticks → 63, 61: L stays 1.
  - Next drain → 59 (< 60): L clears.
- Fault at Nivel=130 (L=M=1, H=0):
  - Falha_sel=1 → L=0 same cycle.
  - Falha_sel=3 → H=1.
  - Falha_sel=0 → L=1, H=0 restored.
- Async reset: drop reset_n mid-fill at Nivel=100, between clock edges → Nivel=INIT_LEVEL and H=M=L=0 immediately. After release, the first Tick comes exactly 4 cycles later.
